// File: rtl/water_raid_pkg.sv
// Shared types and constants for the Water-Raid sprite pipeline.
package water_raid_pkg;

  localparam int NUM_SPRITES = 11;
  localparam int SPRITE_H    = 16;

  localparam logic [3:0] SPR_PLANE     = 4'd0;
  localparam logic [3:0] SPR_ENEMY1    = 4'd1;
  localparam logic [3:0] SPR_ENEMY2    = 4'd2;
  localparam logic [3:0] SPR_ENEMY3    = 4'd3;
  localparam logic [3:0] SPR_ENEMY4    = 4'd4;
  localparam logic [3:0] SPR_ENEMY5    = 4'd5;
  localparam logic [3:0] SPR_ENEMY6    = 4'd6;
  localparam logic [3:0] SPR_ENEMY7    = 4'd7;
  localparam logic [3:0] SPR_ENEMY8    = 4'd8;
  localparam logic [3:0] SPR_BULLET    = 4'd9;
  localparam logic [3:0] SPR_EXPLOSION = 4'd10;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
  } sprite_attr_t;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_SCAN    = 2'd1,
    SCHED_PUBLISH = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sprite_attr_table.sv
// Double-buffered sprite attribute table: software writes the pending copy,
// commit snapshots it into the active copy that the line scanner reads.
module sprite_attr_table
  import water_raid_pkg::sprite_attr_t;
#(
  parameter int NUM_SPRITES = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  sprite_attr_t wdata,
  input  logic         commit,
  input  logic [3:0]   rd_idx,
  output sprite_attr_t rd_attr
);

  localparam logic [3:0] LAST = 4'(NUM_SPRITES - 1);

  sprite_attr_t pend [NUM_SPRITES];
  sprite_attr_t act  [NUM_SPRITES];

  // Non-blocking copy means a commit always takes the pre-write pending data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act[i] <= pend[i];
        end
      end
      if (we && (waddr <= LAST)) begin
        pend[waddr] <= wdata;
      end
    end
  end

  assign rd_attr = (rd_idx <= LAST) ? act[rd_idx] : '0;

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: during hblank, scans the active attribute
// table in priority order and publishes up to SLOTS sprites for the next line.
module sprite_line_scheduler
  import water_raid_pkg::sprite_attr_t;
  import water_raid_pkg::sched_state_t;
#(
  parameter int NUM_SPRITES = water_raid_pkg::NUM_SPRITES,
  parameter int SLOTS       = 4,
  parameter int SPRITE_H    = water_raid_pkg::SPRITE_H
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  attr_we,
  input  logic [3:0]            attr_addr,
  input  logic [9:0]            attr_x,
  input  logic [9:0]            attr_y,
  input  logic                  attr_vis,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic [9:0]            next_line,
  output logic [SLOTS-1:0]      slot_valid,
  output logic [4*SLOTS-1:0]    slot_id,
  output logic [10*SLOTS-1:0]   slot_x,
  output logic [4*SLOTS-1:0]    slot_row,
  output logic                  slots_ready,
  output logic                  overflow,
  output logic                  busy,
  output logic                  sched_err,
  output sched_state_t          state_dbg
);

  localparam int CW = $clog2(SLOTS + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  localparam logic [3:0]    LAST_IDX = 4'(NUM_SPRITES - 1);
  localparam logic [CW-1:0] SLOTS_C  = CW'(SLOTS);
  localparam logic [9:0]    HEIGHT   = 10'(SPRITE_H);

  logic [1:0]    state;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic [9:0]    line_q;
  logic          bld_ovf;
  logic          commit_pend;
  logic          commit;

  logic [3:0]    bld_id  [SLOTS];
  logic [9:0]    bld_x   [SLOTS];
  logic [3:0]    bld_row [SLOTS];

  sprite_attr_t  wr_attr;
  sprite_attr_t  cur;
  logic [9:0]    diff;
  logic          hit;

  assign wr_attr = '{x: attr_x, y: attr_y, vis: attr_vis};

  // A frame_start seen mid-scan is held and applied on the first idle cycle,
  // so a scan never sees the table change under it.
  assign commit = (state == ST_IDLE) && (frame_start || commit_pend);

  sprite_attr_table #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (attr_we),
    .waddr   (attr_addr),
    .wdata   (wr_attr),
    .commit  (commit),
    .rd_idx  (idx),
    .rd_attr (cur)
  );

  // Unsigned wrap makes sprites below the line look far away, i.e. a miss.
  assign diff = line_q - cur.y;
  assign hit  = cur.vis && (diff < HEIGHT);

  assign busy      = (state != ST_IDLE);
  assign state_dbg = sched_state_t'(state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_pend <= 1'b0;
      sched_err   <= 1'b0;
    end else begin
      if (commit) begin
        commit_pend <= 1'b0;
      end else if (frame_start) begin
        commit_pend <= 1'b1;
      end
      if (line_start && (state != ST_IDLE)) begin
        sched_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      line_q  <= '0;
      bld_ovf <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        bld_id[i]  <= '0;
        bld_x[i]   <= '0;
        bld_row[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_start) begin
            line_q  <= next_line;
            idx     <= '0;
            cnt     <= '0;
            bld_ovf <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
              bld_id[i]  <= '0;
              bld_x[i]   <= '0;
              bld_row[i] <= '0;
            end
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            if (cnt < SLOTS_C) begin
              for (int i = 0; i < SLOTS; i++) begin
                if (cnt == CW'(i)) begin
                  bld_id[i]  <= idx;
                  bld_x[i]   <= cur.x;
                  bld_row[i] <= diff[3:0];
                end
              end
              cnt <= cnt + CW'(1);
            end else begin
              bld_ovf <= 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            state <= ST_PUBLISH;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_PUBLISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Unused slots keep stale data; downstream must qualify with slot_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid  <= '0;
      slot_id     <= '0;
      slot_x      <= '0;
      slot_row    <= '0;
      slots_ready <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      slots_ready <= 1'b0;
      if (state == ST_PUBLISH) begin
        slots_ready <= 1'b1;
        overflow    <= bld_ovf;
        for (int i = 0; i < SLOTS; i++) begin
          slot_valid[i] <= (CW'(i) < cnt);
          if (CW'(i) < cnt) begin
            slot_id[4*i +: 4]   <= bld_id[i];
            slot_x[10*i +: 10]  <= bld_x[i];
            slot_row[4*i +: 4]  <= bld_row[i];
          end
        end
      end
    end
  end

endmodule
